// File: rtl/buf_wr_arbiter.sv
// buf_wr_arbiter: round-robin, burst-atomic arbiter sharing one FIFO write port
module buf_wr_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [N_REQ-1:0]            req_i,
  input  logic [N_REQ-1:0]            last_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] data_i,
  output logic [N_REQ-1:0]            ready_o,
  output logic [N_REQ-1:0]            grant_o,
  output logic                        busy_o,
  output logic                        buf_wr_o,
  output logic [DATA_WIDTH-1:0]       buf_wdata_o,
  input  logic                        buf_full_i
);
  localparam int IW = $clog2(N_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]    last_idx_q, last_idx_d, g, pick, idx;
  logic [BW-1:0]    beats_q, beats_d;
  logic             beat, rel, found;
  // encode the one-hot owner into an index
  always_comb begin
    g = '0;
    for (int r = 0; r < N_REQ; r++) if (grant_q[r]) g = IW'(r);
  end
  // first requester after the round-robin pointer wins
  always_comb begin
    pick  = last_idx_q;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = IW'((int'(last_idx_q) + k) % N_REQ);
      if (!found && req_i[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end
  // a beat is an owner write the FIFO can take; release on last, cap or abandon
  always_comb begin
    beat = state_q == GRANT && req_i[g] && !buf_full_i;
    rel  = state_q == GRANT && (!req_i[g] || (beat && (last_i[g] || beats_q == BW'(MAX_BURST - 1))));
  end
  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end
  // next-state logic
  always_comb begin
    state_d = state_q == IDLE ? (|req_i ? GRANT : IDLE) : (rel ? IDLE : GRANT);
  end
  // output logic; write data is muxed from the owner slice unconditionally
  always_comb begin
    ready_o     = (state_q == GRANT && !buf_full_i) ? grant_q : '0;
    grant_o     = grant_q;
    busy_o      = state_q == GRANT;
    buf_wr_o    = beat;
    buf_wdata_o = data_i[g*DATA_WIDTH +: DATA_WIDTH];
  end
  // next values of grant, pointer and beat counter
  always_comb begin
    grant_d    = (state_q == IDLE && |req_i) ? {{(N_REQ-1){1'b0}}, 1'b1} << pick : rel ? '0 : grant_q;
    last_idx_d = rel ? g : last_idx_q;
    beats_d    = state_q == IDLE ? '0 : beat ? beats_q + BW'(1) : beats_q;
  end
  // arbitration registers; pointer resets so requester 0 wins first
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      grant_q    <= '0;
      last_idx_q <= IW'(N_REQ - 1);
      beats_q    <= '0;
    end else begin
      grant_q    <= grant_d;
      last_idx_q <= last_idx_d;
      beats_q    <= beats_d;
    end
  end
endmodule

// File: tb/tb_buf_wr_arbiter.sv
// tb_buf_wr_arbiter: directed and random checks against a behavioural arbiter model
module tb_buf_wr_arbiter;
  localparam int N = 4, DW = 8, MB = 4, DEPTH = 4;
  logic          clk = 0, rst = 1, full = 0;
  logic [N-1:0]  req = '0, last = '0, ready, grant;
  logic [N*DW-1:0] data = '0;
  logic          busy, wr;
  logic [DW-1:0] wdata;
  logic [N-1:0]  s_ready, s_grant;
  logic          s_busy, s_wr;
  logic [DW-1:0] s_wdata;
  int checks = 0, errors = 0;
  int m_owner = -1, m_ptr = N - 1, m_beats = 0;
  int rem [N];
  int seq [N];
  logic [DW-1:0] fifo [$];
  logic [N-1:0] gseq [6];

  buf_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .last_i(last), .data_i(data),
    .ready_o(ready), .grant_o(grant), .busy_o(busy), .buf_wr_o(wr),
    .buf_wdata_o(wdata), .buf_full_i(full));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic [N-1:0] rq, input logic [N-1:0] lt, input logic [N*DW-1:0] dt,
                      input logic fl, input logic rs);
    int g;
    bit bz, bt;
    @(negedge clk);
    req = rq; last = lt; data = dt; full = fl; rst = rs;
    #1;
    s_ready = ready; s_grant = grant; s_busy = busy; s_wr = wr; s_wdata = wdata;
    bz = m_owner >= 0;
    g  = bz ? m_owner : 0;
    bt = bz && rq[g] && !fl;
    chk("grant", 32'(s_grant), bz ? 32'(1) << g : 0);
    chk("ready", 32'(s_ready), (bz && !fl) ? 32'(1) << g : 0);
    chk("busy", 32'(s_busy), 32'(bz));
    chk("wr", 32'(s_wr), 32'(bt));
    if (bt) chk("wdata", 32'(s_wdata), 32'(dt[g*DW +: DW]));
    @(posedge clk);
    if (rs) begin
      m_owner = -1; m_ptr = N - 1; m_beats = 0;
    end else if (!bz) begin
      for (int k = 1; k <= N; k++)
        if (m_owner < 0 && rq[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
      m_beats = 0;
    end else begin
      if (bt) m_beats++;
      if (!rq[g] || (bt && (lt[g] || m_beats == MB))) begin
        m_ptr = g; m_owner = -1;
      end
    end
  endtask

  function automatic logic [N*DW-1:0] word_all();
    logic [N*DW-1:0] v;
    v = '0;
    for (int r = 0; r < N; r++) v[r*DW +: DW] = DW'(r * 64 + seq[r] % 64);
    return v;
  endfunction

  initial begin
    for (int r = 0; r < N; r++) begin rem[r] = 0; seq[r] = 0; end
    step('0, '0, '0, 0, 1);
    step('0, '0, '0, 0, 0);
    chk("reset_grant", 32'(s_grant), 0);
    chk("reset_busy", 32'(s_busy), 0);
    // single burst A1, A2, A3
    step(4'b0001, '0, 32'hA1, 0, 0);
    chk("sb_idle", 32'(s_grant), 0);
    step(4'b0001, '0, 32'hA1, 0, 0);
    chk("sb_g1", 32'(s_grant), 1);
    chk("sb_d1", 32'(s_wdata), 32'hA1);
    step(4'b0001, '0, 32'hA2, 0, 0);
    chk("sb_d2", 32'(s_wdata), 32'hA2);
    step(4'b0001, 4'b0001, 32'hA3, 0, 0);
    chk("sb_d3", 32'(s_wdata), 32'hA3);
    chk("sb_w3", 32'(s_wr), 1);
    step('0, '0, '0, 0, 0);
    chk("sb_after", 32'(s_busy), 0);
    // fairness: 1011 with single-beat bursts, pointer now at 0
    for (int i = 0; i < 6; i++) begin
      step(4'b1011, 4'b1111, '0, 0, 0);
      gseq[i] = s_grant;
    end
    chk("fair0", 32'(gseq[0]), 0);
    chk("fair1", 32'(gseq[1]), 32'b0010);
    chk("fair2", 32'(gseq[2]), 0);
    chk("fair3", 32'(gseq[3]), 32'b1000);
    chk("fair5", 32'(gseq[5]), 32'b0001);
    step('0, '0, '0, 0, 0);
    // burst cap: requester 2 without last
    for (int i = 0; i < 7; i++) begin
      step(4'b0100, '0, 32'h00550000, 0, 0);
      gseq[i % 6] = s_grant;
      if (i == 4) chk("cap_beat4", 32'(s_wr), 1);
      if (i == 5) chk("cap_release", 32'(s_grant), 0);
    end
    chk("cap_regrant", 32'(s_grant), 32'b0100);
    // full stall then resume
    step(4'b0100, '0, 32'h00660000, 1, 0);
    chk("full_ready", 32'(s_ready), 0);
    chk("full_wr", 32'(s_wr), 0);
    chk("full_hold", 32'(s_grant), 32'b0100);
    step(4'b0100, '0, 32'h00660000, 0, 0);
    chk("full_resume", 32'(s_wr), 1);
    // reset mid-burst, then requester 0 wins over 2
    step(4'b0101, '0, '0, 0, 1);
    step(4'b0101, '0, '0, 0, 0);
    chk("rst_grant", 32'(s_grant), 0);
    step(4'b0101, '0, '0, 0, 0);
    chk("rst_first", 32'(s_grant), 32'b0001);
    step('0, '0, '0, 0, 0);
    step('0, '0, '0, 0, 0);
    // random traffic with a small FIFO model providing backpressure
    fifo.delete();
    for (int c = 0; c < 4000; c++) begin
      logic [N-1:0] rq, lt;
      int o;
      for (int r = 0; r < N; r++) begin
        if (rem[r] == 0 && $urandom_range(2) == 0) rem[r] = $urandom_range(1, 6);
        else if (rem[r] > 0 && $urandom_range(24) == 0) rem[r] = 0;
        rq[r] = rem[r] > 0;
        lt[r] = rem[r] == 1;
      end
      step(rq, lt, word_all(), fifo.size() >= DEPTH, $urandom_range(299) == 0);
      o = -1;
      for (int r = 0; r < N; r++) if (rq[r] && s_ready[r]) o = r;
      if (s_wr) begin
        chk("rnd_owner", 32'(o >= 0), 1);
        if (o >= 0) begin
          chk("rnd_sb", 32'(s_wdata), 32'(o * 64 + seq[o] % 64));
          rem[o]--; seq[o]++;
        end
        fifo.push_back(s_wdata);
      end
      if (fifo.size() > 0 && $urandom_range(2) == 0) void'(fifo.pop_front());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/buf_wr_arbiter.md
# buf_wr_arbiter

Round-robin write arbiter that shares one `buffer` FIFO write port among `N_REQ` producers (e.g. UART RX, SPI, debug injector). Each producer gets burst-atomic access: once granted, it keeps the write port until its last beat or `MAX_BURST` beats. The block sits directly in front of the FIFO's `wr_i`/`wdata_i`/`full_o` pins and never issues a write while the FIFO is full.

## Interface
- `N_REQ`, 4: number of requesters (2..8)
- `DATA_WIDTH`, 8: FIFO word width
- `MAX_BURST`, 4: maximum beats per grant (1..16)
- `clk_i` in 1: single clock
- `rst_i` in 1: synchronous, active-high reset
- `req_i` in N_REQ: requester r has a beat to write
- `last_i` in N_REQ: current beat of requester r ends its burst
- `data_i` in N_REQ*DATA_WIDTH: requester r word at bits [r*DATA_WIDTH +: DATA_WIDTH]
- `ready_o` out N_REQ: beat of requester r accepted this cycle when `req_i[r] && ready_o[r]`
- `grant_o` out N_REQ: one-hot current owner, all-zero when idle
- `busy_o` out 1: state is GRANT
- `buf_wr_o` out 1: to FIFO `wr_i`
- `buf_wdata_o` out DATA_WIDTH: to FIFO `wdata_i`
- `buf_full_i` in 1: from FIFO `full_o`

## Operation
- States: IDLE, GRANT. Registers: state, `grant` (one-hot), `last_idx` (round-robin pointer), beat counter `beats` ($clog2(MAX_BURST+1) bits).
- IDLE: if any `req_i` set, pick first set bit scanning `last_idx+1, last_idx+2, …` modulo `N_REQ`; register it into `grant`, clear `beats`, go GRANT. No request: stay IDLE.
- GRANT, owner g:
  - `ready_o[g] = !buf_full_i`; all other `ready_o` bits 0 (combinational).
  - `buf_wr_o = req_i[g] && !buf_full_i`; `buf_wdata_o` = slice g of `data_i` (combinational mux, don't-care value when `buf_wr_o`=0, driven as slice g).
  - Beat = `buf_wr_o`. On beat, `beats` increments.
  - Release (next state IDLE, `grant` cleared, `last_idx`<=g) when: beat with `last_i[g]`=1; or beat making `beats`==`MAX_BURST`; or `req_i[g]`=0 (producer abandoned burst).
  - `buf_full_i`=1: beats stall, grant held indefinitely, no release unless `req_i[g]` drops.
- Requests from non-owners are ignored (not latched) until IDLE.
- `last_i` from non-owners, and `last_i[g]` without a beat, have no effect.
- `MAX_BURST`=1: every beat releases.

## Timing
- Reset (`rst_i`=1 at a clock edge): state IDLE, `grant_o`=0, `ready_o`=0, `buf_wr_o`=0, `busy_o`=0, `beats`=0, `last_idx`=N_REQ-1, so requester 0 wins first arbitration.
- Reset mid-burst: outputs at reset values in the cycle after the edge; words already written stay in the FIFO. No partial-burst cleanup.
- Arbitration latency: request seen in IDLE at edge n; `grant_o`/`ready_o` valid in cycle n+1; first beat can occur in cycle n+1.
- Throughput: 1 beat/cycle while granted and not full.
- Release: after the releasing beat at cycle k, cycle k+1 is IDLE (`buf_wr_o`=0). The next grant is visible in cycle k+2. Mandatory one-cycle gap between bursts.
- `ready_o` and `buf_wr_o` depend combinationally on `buf_full_i` and `req_i`. Producers must not make `req_i` depend on `ready_o`.
- FIFO full asserted during the cycle of a would-be beat: no write, beat retried next cycle, `beats` unchanged.

## Test plan
- Single burst: `req_i`=0001, 3 beats 0xA1,0xA2,0xA3 with `last_i[0]` on third -> `grant_o`=0001 one cycle after req, 3 consecutive `buf_wr_o` pulses, FIFO holds A1,A2,A3, IDLE next cycle.
- Fairness: `req_i`=1011 held, each sends 1-beat bursts -> grant order 0,1,3,0,1,3 with one IDLE cycle between grants.
- Burst cap: `MAX_BURST`=4, requester 2 sends 6 beats without `last_i` -> grant drops after beat 4. With requester 1 also requesting, requester 3 (if requesting) or 0/1 next per pointer=2. Requester 2 regains grant later for beats 5-6.
- Full stall: FIFO pre-filled to `BUF_SIZE`-1, owner sends 3 beats -> 1 write, then `buf_full_i`=1 and `ready_o`=0, no write. Pop one word -> next beat written the cycle after full deasserts. No data lost or duplicated.
- Abandon: owner drops `req_i` after 1 of 3 beats -> IDLE next cycle, `last_idx` = that owner, other requester granted the cycle after.
- Reset mid-burst: `rst_i` pulsed after 2 beats -> all outputs 0 next cycle, next arbitration grants requester 0 first, FIFO contents of the 2 beats preserved.
